finish_ctrl: RTL and testbench

Exit-request controller placed in front of `ext_finish`, the external module that ends simulation. It accepts exit requests from `NREQ` harts through valid/ready handshakes and decides the exit code. Before firing, it waits for the console path (UART) to drain. It then drives the 9-bit `{finish, exitcode}` word to `ext_finish` for exactly one cycle and parks.

---
 rtl/finish_ctrl_pkg.sv | 14 +
 rtl/finish_ctrl_quiet_timer.sv | 42 ++++
 rtl/finish_ctrl.sv | 143 ++++++++++++++
 tb/tb_finish_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/finish_ctrl_pkg.sv
// Shared types and widths for the simulation-exit controller.
package finish_ctrl_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FIRE    = 2'd2,
    HALT    = 2'd3
  } finish_state_t;

  localparam int EXIT_CODE_W  = 8;
  localparam int FINISH_ARG_W = EXIT_CODE_W + 1;

endpackage

// File: rtl/finish_ctrl_quiet_timer.sv
// Counts consecutive console-idle cycles; any busy cycle restarts the count.
module quiet_timer #(
  parameter int DRAIN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count and expiry decode
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (start) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expired = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/finish_ctrl.sv
// Collects per-hart exit requests, picks the exit code, waits for the console
// to go quiet and then pulses {finish, exitcode} for one cycle before parking.
module finish_ctrl
  import finish_ctrl_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic [NREQ-1:0]                          req_valid,
  input  logic [8*NREQ-1:0]                        req_code,
  output logic [NREQ-1:0]                          req_ready,
  input  logic                                     uart_busy,
  output logic [8:0]                               finish_arg,
  output logic                                     done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] winner
);

  localparam int WIN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  finish_state_t                         state_q, state_d;
  logic [NREQ-1:0]                       got_q, got_d;
  logic [NREQ-1:0][EXIT_CODE_W-1:0]      code_q, code_d;
  logic [WIN_W-1:0]                      winner_q, winner_d;
  logic [EXIT_CODE_W-1:0]                sel_code_q, sel_code_d;
  logic [FINISH_ARG_W-1:0]               finish_arg_q, finish_arg_d;
  logic                                  done_q, done_d;

  logic                                  fail_found_s;
  logic [WIN_W-1:0]                      win_idx_s;
  logic [EXIT_CODE_W-1:0]                win_code_s;
  logic                                  timer_start_s;
  logic                                  timer_expired_s;

  // counter is held clear everywhere except DRAIN, so entry always starts at 0
  assign timer_start_s = (state_q != DRAIN);

  quiet_timer #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_quiet_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .start   (timer_start_s),
    .busy    (uart_busy),
    .expired (timer_expired_s)
  );

  // next-state, accept and priority-select logic
  always_comb begin
    state_d      = state_q;
    got_d        = got_q;
    code_d       = code_q;
    winner_d     = winner_q;
    sel_code_d   = sel_code_q;
    finish_arg_d = '0;
    done_d       = done_q;
    fail_found_s = 1'b0;
    win_idx_s    = '0;
    win_code_s   = '0;
    req_ready    = (state_q == COLLECT) ? ~got_q : '0;

    case (state_q)
      COLLECT: begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            got_d[i]  = 1'b1;
            code_d[i] = req_code[EXIT_CODE_W*i +: EXIT_CODE_W];
          end else begin
            got_d[i]  = got_q[i];
          end
        end
        // decision uses the values being latched this edge, so a deciding
        // accept moves on without an extra cycle
        for (int i = 0; i < NREQ; i++) begin
          if (!fail_found_s && got_d[i] && (code_d[i] != '0)) begin
            fail_found_s = 1'b1;
            win_idx_s    = WIN_W'(i);
            win_code_s   = code_d[i];
          end else begin
            fail_found_s = fail_found_s;
          end
        end
        if (fail_found_s || (&got_d)) begin
          winner_d   = win_idx_s;
          sel_code_d = win_code_s;
          if (DRAIN_CYCLES == 0) begin
            state_d      = FIRE;
            finish_arg_d = {1'b1, win_code_s};
          end else begin
            state_d      = DRAIN;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (timer_expired_s) begin
          state_d      = FIRE;
          finish_arg_d = {1'b1, sel_code_q};
        end else begin
          state_d      = DRAIN;
        end
      end
      FIRE: begin
        state_d = HALT;
        done_d  = 1'b1;
      end
      HALT: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= COLLECT;
      got_q        <= '0;
      code_q       <= '0;
      winner_q     <= '0;
      sel_code_q   <= '0;
      finish_arg_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      got_q        <= got_d;
      code_q       <= code_d;
      winner_q     <= winner_d;
      sel_code_q   <= sel_code_d;
      finish_arg_q <= finish_arg_d;
      done_q       <= done_d;
    end
  end

  assign finish_arg = finish_arg_q;
  assign done       = done_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_finish_ctrl.sv
// Drives two controllers (drain 4 and drain 0) with shared stimulus and checks
// them against an idle-cycle-counting reference model.
module tb_finish_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_code = 16'h0000;
  logic        uart_busy = 1'b0;

  logic [1:0]  ready_a, ready_b;
  logic [8:0]  fin_a, fin_b;
  logic        done_a, done_b;
  logic [0:0]  win_a, win_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, index 0 = drain 4 instance, 1 = drain 0 instance
  int         drain_of [2] = '{4, 0};
  bit         got_m    [2][2];
  logic [7:0] code_m   [2][2];
  bit         decided  [2];
  bit         fire_now [2];
  bit         halted   [2];
  int         quiet    [2];
  int         win_m    [2];
  logic [7:0] wcode    [2];

  finish_ctrl #(.NREQ(2), .DRAIN_CYCLES(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready_a), .uart_busy(uart_busy), .finish_arg(fin_a),
    .done(done_a), .winner(win_a)
  );

  finish_ctrl #(.NREQ(2), .DRAIN_CYCLES(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready_b), .uart_busy(uart_busy), .finish_arg(fin_b),
    .done(done_b), .winner(win_b)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        got_m[k][i]  = 1'b0;
        code_m[k][i] = 8'h00;
      end
      decided[k] = 1'b0; fire_now[k] = 1'b0; halted[k] = 1'b0;
      quiet[k] = 0; win_m[k] = 0; wcode[k] = 8'h00;
    end
  endtask

  // effect of the coming rising edge on the model, using current inputs
  task automatic model_step();
    int win;
    for (int k = 0; k < 2; k++) begin
      if (fire_now[k]) begin
        fire_now[k] = 1'b0;
        halted[k]   = 1'b1;
      end else if (halted[k]) begin
        halted[k] = 1'b1;
      end else if (decided[k]) begin
        if (uart_busy) quiet[k] = 0;
        else begin
          quiet[k]++;
          if (quiet[k] == drain_of[k]) fire_now[k] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 2; i++)
          if (req_valid[i] && !got_m[k][i]) begin
            got_m[k][i]  = 1'b1;
            code_m[k][i] = req_code[8*i +: 8];
          end
        win = -1;
        for (int i = 0; i < 2; i++)
          if (win < 0 && got_m[k][i] && code_m[k][i] != 8'h00) win = i;
        if (win >= 0 || (got_m[k][0] && got_m[k][1])) begin
          decided[k] = 1'b1;
          quiet[k]   = 0;
          win_m[k]   = (win >= 0) ? win : 0;
          wcode[k]   = (win >= 0) ? code_m[k][win] : 8'h00;
          if (drain_of[k] == 0) fire_now[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_dut();
    logic [8:0] fin_o;
    logic       done_o;
    logic [0:0] win_o;
    logic [1:0] rdy_o;
    for (int k = 0; k < 2; k++) begin
      fin_o  = (k == 0) ? fin_a   : fin_b;
      done_o = (k == 0) ? done_a  : done_b;
      win_o  = (k == 0) ? win_a   : win_b;
      rdy_o  = (k == 0) ? ready_a : ready_b;
      check_eq($sformatf("d%0d_finish_arg", k), 32'(fin_o),
               fire_now[k] ? 32'({1'b1, wcode[k]}) : 32'd0);
      check_eq($sformatf("d%0d_done", k), 32'(done_o), 32'(halted[k]));
      check_eq($sformatf("d%0d_winner", k), 32'(win_o), 32'(win_m[k]));
      check_eq($sformatf("d%0d_req_ready", k), 32'(rdy_o),
               decided[k] ? 32'd0 : 32'({~got_m[k][1], ~got_m[k][0]}));
    end
  endtask

  task automatic drive(input int kind, input int c);
    req_valid = 2'b00;
    req_code  = 16'h0000;
    uart_busy = 1'b0;
    case (kind)
      0, 3: begin
        if (c == 2) req_valid = 2'b01;
        if (c == 5) req_valid = 2'b10;
        if (kind == 3 && c == 8) uart_busy = 1'b1;
      end
      1: if (c == 3) begin req_valid = 2'b10; req_code = 16'h0700; end
      2: begin
        if (c == 2) begin req_valid = 2'b11; req_code = 16'h0905; end
        else if (c >= 8) begin req_valid = 2'b11; req_code = 16'h0303; end
      end
      5: begin
        if (c == 2) req_valid = 2'b01;
        if (c == 4) req_valid = 2'b10;
        if (c == 7) begin RST_N = 1'b0; model_reset(); end
        if (c == 9) RST_N = 1'b1;
        if (c == 11) req_valid = 2'b11;
      end
      default: begin
        for (int i = 0; i < 2; i++) begin
          req_valid[i] = ($urandom_range(0, 3) == 0);
          req_code[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
        uart_busy = ($urandom_range(0, 5) == 0);
      end
    endcase
  endtask

  task automatic run_episode(input int kind);
    int fire_a, fire_b, done_a_c, exp_fa, exp_fb;
    fire_a = -1; fire_b = -1; done_a_c = -1;
    exp_fa = (kind == 0) ? 10 : (kind == 1) ? 8 : (kind == 3) ? 13 : (kind == 5) ? 16 : -1;
    exp_fb = (kind == 0) ? 6 : (kind == 1) ? 4 : (kind == 3) ? 6 : -1;
    @(posedge CLK); #1;
    RST_N = 1'b0; req_valid = 2'b00; req_code = 16'h0000; uart_busy = 1'b0;
    model_reset();
    @(negedge CLK);
    check_dut();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      drive(kind, c);
      @(negedge CLK);
      check_dut();
      if (fin_a[8] && fire_a < 0) fire_a = c;
      if (fin_b[8] && fire_b < 0) fire_b = c;
      if (done_a && done_a_c < 0) done_a_c = c;
      if (RST_N) model_step();
    end
    if (exp_fa >= 0) check_eq($sformatf("k%0d_fire_cycle_a", kind), 32'(fire_a), 32'(exp_fa));
    if (exp_fb >= 0) check_eq($sformatf("k%0d_fire_cycle_b", kind), 32'(fire_b), 32'(exp_fb));
    if (kind == 0) check_eq("k0_done_cycle_a", 32'(done_a_c), 32'd11);
  endtask

  initial begin
    model_reset();
    run_episode(0);
    run_episode(1);
    run_episode(2);
    run_episode(3);
    run_episode(5);
    for (int e = 0; e < 15; e++) run_episode(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
